// File: rtl/serial_link_host.sv
`default_nettype none
// ============================================================================
// Module   : serial_link_host
// Brief    : Serialises a message block and expanded key MSB-first, then
//            gathers the serial result back into a parallel block.
// Revision : 1.0
// ============================================================================
module serial_link_host #(
    parameter int nk      = 8,
    parameter int nb      = 4,
    parameter int nr      = 14,
    parameter int TIMEOUT = 4096
) (
    input  logic                        in_clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [32*nb-1:0]            in_msg,
    input  logic [32*nb*(nr+1)-1:0]     in_key,
    output logic                        out_en,
    output logic                        out_real_msg,
    output logic                        out_real_key,
    input  logic                        in_res_bit,
    input  logic                        in_res_valid,
    output logic                        busy,
    output logic [32*nb-1:0]            out_result,
    output logic                        result_valid,
    output logic                        timeout_err
);

    localparam int MW = 32*nb;
    localparam int KW = 32*nb*(nr+1);
    localparam int CW = $clog2(KW+1);
    localparam int TW = $clog2(TIMEOUT+1);

    localparam logic [CW-1:0] C_MSG_LAST = CW'(MW-1);
    localparam logic [CW-1:0] C_KEY_LAST = CW'(KW-1);
    localparam logic [TW-1:0] C_TOUT     = TW'(TIMEOUT);

    if (nk < 4 || nk > 8) begin : g_nk_check
        $error("serial_link_host: nk must be in 4..8");
    end

    typedef enum logic [2:0] {IDLE, MSG, KEY, WAIT_RES, DONE} state_t;

    state_t          r_state, w_state_next;
    logic [MW-1:0]   r_msg_sr, w_msg_next;
    logic [KW-1:0]   r_key_sr, w_key_next;
    logic [MW-1:0]   r_res_sr, w_res_next;
    logic [CW-1:0]   r_bitcnt, w_bitcnt_next;
    logic [TW-1:0]   r_tcnt,   w_tcnt_next;
    logic            w_tout_next;

    always_ff @(posedge in_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_msg_sr <= '0;
            r_key_sr <= '0;
            r_res_sr <= '0;
            r_bitcnt <= '0;
            r_tcnt   <= '0;
        end else begin
            r_state  <= w_state_next;
            r_msg_sr <= w_msg_next;
            r_key_sr <= w_key_next;
            r_res_sr <= w_res_next;
            r_bitcnt <= w_bitcnt_next;
            r_tcnt   <= w_tcnt_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_msg_next    = r_msg_sr;
        w_key_next    = r_key_sr;
        w_res_next    = r_res_sr;
        w_bitcnt_next = r_bitcnt;
        w_tcnt_next   = r_tcnt;
        w_tout_next   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_msg_next    = in_msg;
                    w_key_next    = in_key;
                    w_bitcnt_next = '0;
                    w_state_next  = MSG;
                end
            end
            MSG: begin
                w_msg_next = {r_msg_sr[MW-2:0], 1'b0};
                if (r_bitcnt == C_MSG_LAST) begin
                    w_bitcnt_next = '0;
                    w_state_next  = KEY;
                end else begin
                    w_bitcnt_next = r_bitcnt + 1'b1;
                end
            end
            KEY: begin
                w_key_next = {r_key_sr[KW-2:0], 1'b0};
                if (r_bitcnt == C_KEY_LAST) begin
                    w_bitcnt_next = '0;
                    w_tcnt_next   = '0;
                    w_state_next  = WAIT_RES;
                end else begin
                    w_bitcnt_next = r_bitcnt + 1'b1;
                end
            end
            WAIT_RES: begin
                // The error pulse is shown while still busy; leave on the next edge.
                if (r_tcnt == C_TOUT) begin
                    w_state_next = IDLE;
                end else if (in_res_valid) begin
                    w_res_next  = {r_res_sr[MW-2:0], in_res_bit};
                    w_tcnt_next = '0;
                    if (r_bitcnt == C_MSG_LAST) begin
                        w_bitcnt_next = '0;
                        w_state_next  = DONE;
                    end else begin
                        w_bitcnt_next = r_bitcnt + 1'b1;
                    end
                end else begin
                    w_tcnt_next = r_tcnt + 1'b1;
                    w_tout_next = (w_tcnt_next == C_TOUT);
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Outputs are flopped copies of what the next state will present.
    always_ff @(posedge in_clk or negedge rst_n) begin
        if (!rst_n) begin
            out_en       <= 1'b0;
            out_real_msg <= 1'b0;
            out_real_key <= 1'b0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            timeout_err  <= 1'b0;
            out_result   <= '0;
        end else begin
            out_en       <= (w_state_next == MSG) || (w_state_next == KEY);
            out_real_msg <= (w_state_next == MSG) && w_msg_next[MW-1];
            out_real_key <= (w_state_next == KEY) && w_key_next[KW-1];
            busy         <= (w_state_next != IDLE);
            result_valid <= (w_state_next == DONE);
            timeout_err  <= w_tout_next;
            if (w_state_next == DONE) begin
                out_result <= w_res_next;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_link_host.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_link_host
// Brief    : Directed self-checking bench for serial_link_host.
// Revision : 1.0
// ============================================================================
module tb_serial_link_host;

    localparam int MW = 128;
    localparam int KW = 1920;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [MW-1:0] in_msg;
    logic [KW-1:0] in_key;
    logic          out_en;
    logic          out_real_msg;
    logic          out_real_key;
    logic          in_res_bit;
    logic          in_res_valid;
    logic          busy;
    logic [MW-1:0] out_result;
    logic          result_valid;
    logic          timeout_err;

    int checks = 0;
    int errors = 0;

    logic [MW-1:0] msg_v;
    logic [127:0]  key_chunk;
    logic [KW-1:0] key_v;
    logic [MW-1:0] res_v;
    logic [MW-1:0] m_rec;
    logic [KW-1:0] k_rec;
    int            en_cnt;
    int            stray;
    int            flag;
    int            en_seen;
    int            n;

    serial_link_host dut (
        .in_clk       (clk),
        .rst_n        (rst_n),
        .start        (start),
        .in_msg       (in_msg),
        .in_key       (in_key),
        .out_en       (out_en),
        .out_real_msg (out_real_msg),
        .out_real_key (out_real_key),
        .in_res_bit   (in_res_bit),
        .in_res_valid (in_res_valid),
        .busy         (busy),
        .out_result   (out_result),
        .result_valid (result_valid),
        .timeout_err  (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Records one 2048-cycle window starting at the current sample point.
    task automatic run_frame(input bit tog, output int cnt, output logic [MW-1:0] m,
                             output logic [KW-1:0] k, output int bad);
        cnt = 0; bad = 0; m = '0; k = '0;
        for (int i = 0; i < MW + KW; i++) begin
            if (out_en === 1'b1) cnt++;
            if (i < MW) begin
                m = {m[MW-2:0], out_real_msg};
                if (out_real_key !== 1'b0) bad++;
            end else begin
                k = {k[KW-2:0], out_real_key};
                if (out_real_msg !== 1'b0) bad++;
            end
            in_res_valid = tog & i[0];
            in_res_bit   = 1'b1;
            tick();
        end
        in_res_valid = 1'b0;
        in_res_bit   = 1'b0;
    endtask

    // Sends MW result bits; returns early-pulse and out_en activity flags.
    task automatic feed(input logic [MW-1:0] v, input bit gaps, output int early, output int ens);
        early = 0; ens = 0;
        for (int i = 0; i < MW; i++) begin
            if (gaps) begin
                for (int g = 0; g < (i % 4); g++) begin
                    in_res_valid = 1'b0;
                    tick();
                    if (result_valid !== 1'b0) early++;
                    if (out_en !== 1'b0) ens++;
                end
            end
            in_res_valid = 1'b1;
            in_res_bit   = v[MW-1-i];
            tick();
            if (i < MW - 1 && result_valid !== 1'b0) early++;
            if (out_en !== 1'b0) ens++;
        end
        in_res_valid = 1'b0;
        in_res_bit   = 1'b0;
    endtask

    initial begin
        msg_v     = 128'h00112233445566778899aabbccddeeff;
        key_chunk = 128'h000102030405060708090a0b0c0d0e0f;
        key_v     = {15{key_chunk}};
        res_v     = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        rst_n = 1'b0; start = 1'b0; in_msg = msg_v; in_key = key_v;
        in_res_bit = 1'b0; in_res_valid = 1'b0;

        repeat (3) tick();
        check("rst_out_en", out_en, 0);
        check("rst_busy", busy, 0);
        check("rst_outs", {out_real_msg, out_real_key, result_valid, timeout_err}, 0);
        check("rst_result", out_result, 0);
        rst_n = 1'b1;
        tick();
        check("idle_busy", busy, 0);

        // Frame with start held high and result bits offered during MSG/KEY
        start = 1'b1;
        tick();
        check("c_first_en", out_en, 1);
        run_frame(1'b1, en_cnt, m_rec, k_rec, stray);
        check("c_en_count", en_cnt, 2048);
        check("c_en_off", out_en, 0);
        check("c_busy_wait", busy, 1);
        feed('0, 1'b0, flag, en_seen);
        check("c_no_early_valid", flag, 0);
        check("c_no_second_frame", en_seen, 0);
        check("c_result_valid", result_valid, 1);
        check("c_result_zero", out_result, 0);
        check("c_busy_done", busy, 1);
        tick();
        check("c_rv_pulse", result_valid, 0);
        check("c_idle_busy", busy, 0);
        check("c_idle_en", out_en, 0);
        tick();
        check("c_restart_en", out_en, 1);
        check("c_restart_busy", busy, 1);
        start  = 1'b0;
        in_msg = ~msg_v;
        in_key = ~key_v;

        // Frame A: reconstruct msg/key, inputs altered after capture
        run_frame(1'b0, en_cnt, m_rec, k_rec, stray);
        check("a_en_count", en_cnt, 2048);
        check("a_msg", m_rec, msg_v);
        for (int j = 0; j < 15; j++) begin
            check($sformatf("a_key_%0d", j), k_rec[j*128 +: 128], key_chunk);
        end
        check("a_stray", stray, 0);
        check("a_en_off", out_en, 0);
        feed(res_v, 1'b1, flag, en_seen);
        check("a_no_early_valid", flag, 0);
        check("a_result_valid", result_valid, 1);
        check("a_result", out_result, res_v);
        tick();
        check("a_rv_pulse", result_valid, 0);
        check("a_idle_busy", busy, 0);
        check("a_result_hold", out_result, res_v);

        // Frame B: timeout in WAIT_RES
        in_msg = msg_v; in_key = key_v;
        start = 1'b1;
        tick();
        start = 1'b0;
        run_frame(1'b0, en_cnt, m_rec, k_rec, stray);
        check("b_en_count", en_cnt, 2048);
        n = 0;
        flag = 0;
        while (timeout_err !== 1'b1 && n < 5000) begin
            tick();
            n++;
            if (result_valid !== 1'b0) flag++;
        end
        check("b_timeout_cycles", n, 4096);
        check("b_busy_at_err", busy, 1);
        check("b_no_rv", flag, 0);
        tick();
        check("b_err_pulse", timeout_err, 0);
        check("b_busy_drop", busy, 0);
        check("b_result_kept", out_result, res_v);

        // Frame D: asynchronous reset at key bit 500
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (MW + 500) tick();
        check("d_key500_en", out_en, 1);
        check("d_key500_bit", out_real_key, key_v[KW-1-500]);
        rst_n = 1'b0;
        #2;
        check("d_async_en", out_en, 0);
        check("d_async_busy", busy, 0);
        check("d_async_result", out_result, 0);
        check("d_async_outs", {out_real_msg, out_real_key, result_valid, timeout_err}, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("d_post_busy", busy, 0);
        check("d_post_en", out_en, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        run_frame(1'b0, en_cnt, m_rec, k_rec, stray);
        check("d_en_count", en_cnt, 2048);
        check("d_msg", m_rec, msg_v);
        check("d_key_top", k_rec[KW-1 -: 128], key_chunk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
